// File: rtl/wb_com_pkg.sv
// wb_com_pkg: shared widths, slave-index decode and per-slave lock state for the wishbone crossbar
package wb_com_pkg;
  localparam int WB_COM_AWIDTH = 32;
  localparam int WB_COM_DWIDTH = 32;
  typedef struct packed {
    logic       valid;
    logic [2:0] owner;
  } lock_t;
  function automatic logic [7:0] slv_idx(input logic [63:0] adr, input int unsigned aw, input int unsigned iw);
    return 8'((adr >> (aw - iw)) & ((64'd1 << iw) - 64'd1));
  endfunction
endpackage

// File: rtl/wb_rr_arb.sv
// wb_rr_arb: round-robin arbiter, one-hot grant, priority starts at the requester after the last winner
module wb_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, win;
  always_comb begin
    gnt = '0;
    win = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        win = PW'(j);
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (en && |req) ptr <= PW'((int'(win) + 1) % N);
endmodule

// File: rtl/wb_com_nxm.sv
// wb_com_nxm: N_MST x N_SLV pipelined wishbone crossbar with per-slave round-robin locks and an error responder
module wb_com_nxm
  import wb_com_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int N_SLV  = 2,
  parameter int AWIDTH = WB_COM_AWIDTH,
  parameter int DWIDTH = WB_COM_DWIDTH,
  parameter int IDX_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MST*AWIDTH-1:0]       m_wb_adr_i,
  input  logic [N_MST*DWIDTH-1:0]       m_wb_dat_i,
  input  logic [N_MST*(DWIDTH/8)-1:0]   m_wb_sel_i,
  input  logic [N_MST-1:0]              m_wb_cyc_i,
  input  logic [N_MST-1:0]              m_wb_stb_i,
  input  logic [N_MST-1:0]              m_wb_we_i,
  output logic [N_MST*DWIDTH-1:0]       m_wb_dat_o,
  output logic [N_MST-1:0]              m_wb_stall_o,
  output logic [N_MST-1:0]              m_wb_ack_o,
  output logic [N_MST-1:0]              m_wb_err_o,
  output logic [N_SLV*AWIDTH-1:0]       s_wb_adr_o,
  output logic [N_SLV*DWIDTH-1:0]       s_wb_dat_o,
  output logic [N_SLV*(DWIDTH/8)-1:0]   s_wb_sel_o,
  output logic [N_SLV-1:0]              s_wb_cyc_o,
  output logic [N_SLV-1:0]              s_wb_stb_o,
  output logic [N_SLV-1:0]              s_wb_we_o,
  input  logic [N_SLV*DWIDTH-1:0]       s_wb_dat_i,
  input  logic [N_SLV-1:0]              s_wb_stall_i,
  input  logic [N_SLV-1:0]              s_wb_ack_i,
  input  logic [N_SLV-1:0]              s_wb_err_i
);
  localparam int SW = DWIDTH / 8;
  lock_t            lk_a [N_SLV];
  logic [N_MST-1:0] gnt [N_SLV];
  logic [N_SLV-1:0] own_v;
  logic [2:0]       own_k [N_SLV];
  logic [N_MST-1:0] act, unm, locked, er_q;
  logic [7:0]       tgt [N_MST];
  always_comb begin
    act = '0;
    unm = '0;
    locked = '0;
    for (int k = 0; k < N_MST; k++) begin
      act[k] = m_wb_cyc_i[k] & m_wb_stb_i[k];
      tgt[k] = slv_idx(64'(m_wb_adr_i[k*AWIDTH +: AWIDTH]), AWIDTH, IDX_W);
      unm[k] = int'(tgt[k]) >= N_SLV;
      for (int s = 0; s < N_SLV; s++) locked[k] |= lk_a[s].valid & (lk_a[s].owner == 3'(k));
    end
  end
  for (genvar s = 0; s < N_SLV; s++) begin : g_slv
    lock_t             lk;
    logic [N_MST-1:0]  req;
    logic [2:0]        gk;
    logic              rel, cyc, stb, we;
    logic [AWIDTH-1:0] adr;
    logic [DWIDTH-1:0] dat;
    logic [SW-1:0]     sel;
    // new grants only from idle slaves, so a release and a fresh grant never share a cycle
    always_comb
      for (int k = 0; k < N_MST; k++)
        req[k] = rst_n & ~lk.valid & act[k] & ~locked[k] & (tgt[k] == 8'(s));
    wb_rr_arb #(.N(N_MST)) u_arb (.clk, .rst_n, .en(~lk.valid), .req, .gnt(gnt[s]));
    always_comb begin
      gk = '0;
      rel = 1'b0;
      for (int k = 0; k < N_MST; k++) begin
        if (gnt[s][k]) gk = 3'(k);
        if (lk.owner == 3'(k)) rel = ~m_wb_cyc_i[k];
      end
    end
    assign lk_a[s]  = lk;
    assign own_v[s] = lk.valid | (|gnt[s]);
    assign own_k[s] = lk.valid ? lk.owner : gk;
    always_comb begin
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      adr = '0;
      dat = '0;
      sel = '0;
      for (int k = 0; k < N_MST; k++)
        if (own_v[s] && own_k[s] == 3'(k)) begin
          cyc = m_wb_cyc_i[k];
          stb = m_wb_stb_i[k];
          we  = m_wb_we_i[k];
          adr = m_wb_adr_i[k*AWIDTH +: AWIDTH];
          dat = m_wb_dat_i[k*DWIDTH +: DWIDTH];
          sel = m_wb_sel_i[k*SW +: SW];
        end
    end
    assign s_wb_cyc_o[s] = cyc;
    assign s_wb_stb_o[s] = stb;
    assign s_wb_we_o[s]  = we;
    assign s_wb_adr_o[s*AWIDTH +: AWIDTH] = adr;
    assign s_wb_dat_o[s*DWIDTH +: DWIDTH] = dat;
    assign s_wb_sel_o[s*SW +: SW]         = sel;
    always_ff @(posedge clk)
      if (!rst_n) lk <= '0;
      else if (lk.valid && rel) lk.valid <= 1'b0;
      else if (!lk.valid && |gnt[s]) lk <= '{valid: 1'b1, owner: gk};
  end
  // responses follow the registered lock only; anything from an idle slave is discarded
  always_comb begin
    m_wb_dat_o   = '0;
    m_wb_ack_o   = '0;
    m_wb_err_o   = er_q;
    m_wb_stall_o = act & ~unm;
    for (int k = 0; k < N_MST; k++)
      for (int s = 0; s < N_SLV; s++) begin
        if (own_v[s] && own_k[s] == 3'(k)) m_wb_stall_o[k] = s_wb_stall_i[s];
        if (lk_a[s].valid && lk_a[s].owner == 3'(k)) begin
          m_wb_ack_o[k] = m_wb_ack_o[k] | s_wb_ack_i[s];
          m_wb_err_o[k] = m_wb_err_o[k] | s_wb_err_i[s];
          if (s_wb_ack_i[s] | s_wb_err_i[s]) m_wb_dat_o[k*DWIDTH +: DWIDTH] = s_wb_dat_i[s*DWIDTH +: DWIDTH];
        end
      end
  end
  always_ff @(posedge clk)
    if (!rst_n) er_q <= '0;
    else er_q <= act & unm & ~locked;
endmodule

// File: tb/tb_wb_com_nxm.sv
// tb_wb_com_nxm: directed stimulus with a response scoreboard for the 2x2 configuration of wb_com_nxm
module tb_wb_com_nxm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [63:0] m_adr, m_dat, m_rd, s_adr, s_dat, s_rd;
  logic [7:0]  m_sel, s_sel;
  logic [1:0]  m_cyc, m_stb, m_we, m_stall, m_ack, m_err;
  logic [1:0]  s_cyc, s_stb, s_we, s_stall, s_ack, s_err, mdl_ack, ack_inj;
  logic [31:0] rdata [2];
  logic [33:0] q0 [$];
  logic [33:0] q1 [$];
  int n_cmp = 0;
  int n_bad = 0;

  wb_com_nxm #(.N_MST(2), .N_SLV(2), .AWIDTH(32), .DWIDTH(32), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dat), .m_wb_sel_i(m_sel),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
    .m_wb_dat_o(m_rd), .m_wb_stall_o(m_stall), .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat), .s_wb_sel_o(s_sel),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_dat_i(s_rd), .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err)
  );

  // slave model: ack one cycle after each accepted strobe, returning the data staged in rdata
  assign s_ack = mdl_ack | ack_inj;
  assign s_err = '0;
  always @(posedge clk) begin
    if (!rst_n) mdl_ack <= '0;
    else mdl_ack <= s_cyc & s_stb & ~s_stall;
    s_rd <= {rdata[1], rdata[0]};
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int k, input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
    m_cyc[k] = c;
    m_stb[k] = s;
    m_we[k]  = w;
    m_adr[k*32 +: 32] = a;
    m_dat[k*32 +: 32] = d;
    m_sel[k*4 +: 4]   = 4'hF;
  endtask

  task automatic push(input int k, input logic e, input logic [31:0] d);
    if (k == 0) q0.push_back({~e, e, d});
    else q1.push_back({~e, e, d});
  endtask

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (m_ack[k] | m_err[k]) begin
        logic [33:0] got, want;
        got = {m_ack[k], m_err[k], m_rd[k*32 +: 32]};
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL resp m%0d unexpected: got %h expected none", k, got);
        end else begin
          want = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("resp m%0d", k), 64'(got), 64'(want));
        end
      end

  initial begin
    m_adr = '0; m_dat = '0; m_sel = '0; m_cyc = '0; m_stb = '0; m_we = '0;
    s_stall = '0; ack_inj = '0; rdata[0] = '0; rdata[1] = '0;
    repeat (2) step;
    rst_n = 1'b1;
    #2;
    chk("rst s_cyc", 64'(s_cyc), 0);
    chk("rst s_stb", 64'(s_stb), 0);
    chk("rst m_ack", 64'(m_ack), 0);
    chk("rst m_err", 64'(m_err), 0);
    chk("rst m_stall", 64'(m_stall), 0);
    // contention after reset: M0 first, M1 on the cycle after M0 drops cyc
    step;
    drv(0, 1, 1, 0, 32'h0, 0);
    drv(1, 1, 1, 0, 32'h8, 0);
    rdata[0] = 32'h1111_0000;
    push(0, 0, 32'h1111_0000);
    #2;
    chk("arb0 stall", 64'(m_stall), 64'b10);
    chk("arb0 s_cyc", 64'(s_cyc), 64'b01);
    chk("arb0 s0 adr", 64'(s_adr[31:0]), 64'h0);
    chk("arb0 idle dat", m_rd, 0);
    step;
    m_stb[0] = 1'b0;
    #2;
    chk("arb0 m1 blocked", 64'(m_stall[1]), 1);
    chk("arb0 s_stb", 64'(s_stb), 0);
    step;
    m_cyc[0] = 1'b0;
    rdata[0] = 32'h2222_0000;
    #2;
    chk("handover stall", 64'(m_stall[1]), 1);
    chk("handover s_cyc", 64'(s_cyc), 0);
    step;
    push(1, 0, 32'h2222_0000);
    #2;
    chk("arb1 stall", 64'(m_stall), 0);
    chk("arb1 s_stb", 64'(s_stb), 64'b01);
    chk("arb1 s0 adr", 64'(s_adr[31:0]), 64'h8);
    step; m_stb[1] = 1'b0;
    step; m_cyc[1] = 1'b0;
    step; step;
    // single read
    drv(0, 1, 1, 0, 32'h10, 0);
    rdata[0] = 32'hDEAD_BEEF;
    push(0, 0, 32'hDEAD_BEEF);
    #2;
    chk("rd stall", 64'(m_stall[0]), 0);
    chk("rd s_cyc", 64'(s_cyc), 64'b01);
    chk("rd s0 adr", 64'(s_adr[31:0]), 64'h10);
    chk("rd s_we", 64'(s_we), 0);
    step;
    m_stb[0] = 1'b0;
    #2;
    chk("rd s1 idle", 64'(s_cyc), 64'b01);
    step; m_cyc[0] = 1'b0;
    step; step;
    // last owner of S0 is M0, so M1 wins the next tie
    drv(0, 1, 1, 0, 32'hC, 0);
    drv(1, 1, 1, 0, 32'h14, 0);
    rdata[0] = 32'h3333_0000;
    push(1, 0, 32'h3333_0000);
    #2;
    chk("rot stall", 64'(m_stall), 64'b01);
    chk("rot s0 adr", 64'(s_adr[31:0]), 64'h14);
    step;
    m_stb[1] = 1'b0;
    rdata[0] = 32'h4444_0000;
    #2;
    chk("rot m0 blocked", 64'(m_stall), 64'b01);
    step;
    m_cyc[1] = 1'b0;
    #2;
    chk("rot release stall", 64'(m_stall), 64'b01);
    step;
    push(0, 0, 32'h4444_0000);
    #2;
    chk("rot m0 grant", 64'(m_stall), 0);
    chk("rot m0 adr", 64'(s_adr[31:0]), 64'hC);
    step; m_stb[0] = 1'b0;
    step; m_cyc[0] = 1'b0;
    step; step;
    // parallel: M0 writes S0 while M1 reads S1, S1 stalls the first cycle
    drv(0, 1, 1, 1, 32'h4, 32'hA5A5_0001);
    drv(1, 1, 1, 0, 32'h4000_0000, 0);
    rdata[0] = 32'h5555_0000;
    rdata[1] = 32'h6666_0000;
    s_stall = 2'b10;
    push(0, 0, 32'h5555_0000);
    #2;
    chk("par stall", 64'(m_stall), 64'b10);
    chk("par s_cyc", 64'(s_cyc), 64'b11);
    chk("par s_we", 64'(s_we), 64'b01);
    chk("par s0 dat", 64'(s_dat[31:0]), 64'hA5A5_0001);
    chk("par s1 adr", 64'(s_adr[63:32]), 64'h4000_0000);
    step;
    m_stb[0] = 1'b0;
    s_stall = '0;
    push(1, 0, 32'h6666_0000);
    #2;
    chk("par stall2", 64'(m_stall), 0);
    chk("par s_stb2", 64'(s_stb), 64'b10);
    step; m_stb[1] = 1'b0; m_cyc[0] = 1'b0;
    step; m_cyc[1] = 1'b0;
    step; step;
    // unmapped: three back-to-back strobes, err one cycle after each
    drv(1, 1, 1, 0, 32'h8000_0000, 0);
    push(1, 1, 0);
    #2;
    chk("unm stall", 64'(m_stall), 0);
    chk("unm s_cyc", 64'(s_cyc), 0);
    chk("unm err early", 64'(m_err), 0);
    step;
    push(1, 1, 0);
    #2;
    chk("unm stall2", 64'(m_stall), 0);
    chk("unm s_cyc2", 64'(s_cyc), 0);
    step;
    push(1, 1, 0);
    #2;
    chk("unm s_cyc3", 64'(s_cyc), 0);
    step;
    drv(1, 0, 0, 0, 0, 0);
    step;
    #2;
    chk("unm err done", 64'(m_err), 0);
    // lock stickiness: S1 address inside an S0 cycle stays on S0
    drv(0, 1, 1, 0, 32'h0, 0);
    rdata[0] = 32'h7777_0000;
    push(0, 0, 32'h7777_0000);
    #2;
    chk("stk s_cyc", 64'(s_cyc), 64'b01);
    step;
    m_adr[31:0] = 32'h4000_0000;
    rdata[0] = 32'h8888_0000;
    push(0, 0, 32'h8888_0000);
    #2;
    chk("stk s_stb", 64'(s_stb), 64'b01);
    chk("stk s_cyc2", 64'(s_cyc), 64'b01);
    chk("stk s0 adr", 64'(s_adr[31:0]), 64'h4000_0000);
    chk("stk stall", 64'(m_stall), 0);
    step; m_stb[0] = 1'b0;
    step; m_cyc[0] = 1'b0;
    step; step;
    // reset while M0 owns S0 and keeps strobing
    drv(0, 1, 1, 0, 32'h0, 0);
    rdata[0] = 32'h9999_0000;
    push(0, 0, 32'h9999_0000);
    step;
    rst_n = 1'b0;
    step;
    ack_inj = 2'b01;
    #2;
    chk("mrst s_cyc", 64'(s_cyc), 0);
    chk("mrst s_stb", 64'(s_stb), 0);
    chk("mrst m_ack", 64'(m_ack), 0);
    chk("mrst m_err", 64'(m_err), 0);
    step;
    rst_n = 1'b1;
    ack_inj = '0;
    drv(0, 0, 0, 0, 0, 0);
    step;
    drv(1, 1, 1, 0, 32'h20, 0);
    rdata[0] = 32'hAAAA_0000;
    push(1, 0, 32'hAAAA_0000);
    #2;
    chk("post rst stall", 64'(m_stall), 0);
    chk("post rst s_stb", 64'(s_stb), 64'b01);
    step; m_stb[1] = 1'b0;
    step; m_cyc[1] = 1'b0;
    step; step;
    chk("m0 pending", 64'(q0.size()), 0);
    chk("m1 pending", 64'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
